rcv_loss_detect: RTL and testbench

Receive-side loss detector for the UDT core: consumes the sequence number of every accepted data packet and tracks the largest sequence received. It emits gap ranges (`insertStart/insertEnd`) and late/retransmitted sequence removals toward the receiver loss list, which also drives NAK generation. It sits between the packet parser and the receive loss list, one per connection.

---
 rtl/udt_seq_pkg.sv | 36 +++
 rtl/rcv_loss_detect_if.sv | 38 +++
 rtl/udt_seq_off.sv | 28 ++
 rtl/rcv_loss_detect.sv | 129 ++++++++++++
 tb/tb_rcv_loss_detect.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/udt_seq_pkg.sv
// ============================================================================
// Module : udt_seq_pkg
// Brief  : Shared UDT sequence-number constants, 31-bit modular helpers and
//          receive loss detector state encoding.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package udt_seq_pkg;

    localparam logic [31:0] MAX_SEQ_NO = 32'h7FFF_FFFF;
    localparam logic [31:0] SEQ_THRESH = 32'h3FFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_READY  = 2'd1,
        ST_INSERT = 2'd2,
        ST_REMOVE = 2'd3
    } rld_state_e;

    // 31-bit operands make the modulo 2^31 wrap implicit.
    function automatic logic [30:0] seq_inc(input logic [30:0] seq);
        return seq + 31'd1;
    endfunction

    function automatic logic [30:0] seq_dec(input logic [30:0] seq);
        return seq - 31'd1;
    endfunction

    function automatic logic [30:0] seq_off(input logic [30:0] seq, input logic [30:0] ref_seq);
        return seq - ref_seq;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rcv_loss_detect_if.sv
// ============================================================================
// Module : rcv_loss_detect_if
// Brief  : Sequence input and insert/remove output handshakes of the loss
//          detector; slave is the detector, master the parser/loss-list side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rcv_loss_detect_if;

    logic [31:0] seq_i;
    logic        seq_valid_i;
    logic        seq_ready_o;

    logic [31:0] insertStart_o;
    logic [31:0] insertEnd_o;
    logic        insert_valid_o;
    logic        insert_ready_i;

    logic [31:0] remove_item_o;
    logic        remove_valid_o;
    logic        remove_ready_i;

    modport slave (
        input  seq_i, seq_valid_i, insert_ready_i, remove_ready_i,
        output seq_ready_o, insertStart_o, insertEnd_o, insert_valid_o,
               remove_item_o, remove_valid_o
    );

    modport master (
        output seq_i, seq_valid_i, insert_ready_i, remove_ready_i,
        input  seq_ready_o, insertStart_o, insertEnd_o, insert_valid_o,
               remove_item_o, remove_valid_o
    );

endinterface

`default_nettype wire

// File: rtl/udt_seq_off.sv
// ============================================================================
// Module : udt_seq_off
// Brief  : Combinational 31-bit modular sequence offset with before/after
//          classification; shared by receive and ACK logic.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module udt_seq_off
    import udt_seq_pkg::*;
#(
    parameter logic [31:0] THRESH = udt_seq_pkg::SEQ_THRESH
) (
    input  wire logic [30:0] seq,
    input  wire logic [30:0] ref_seq,
    output logic      [30:0] off,
    output logic             is_before,
    output logic             is_zero
);

    assign off       = seq_off(seq, ref_seq);
    // Offsets past the threshold are negative in two's-complement terms.
    assign is_before = ({1'b0, off} > THRESH);
    assign is_zero   = (off == 31'd0);

endmodule

`default_nettype wire

// File: rtl/rcv_loss_detect.sv
// ============================================================================
// Module : rcv_loss_detect
// Brief  : Receive-side loss detector: tracks largest received sequence and
//          emits gap inserts / late-packet removes toward the loss list.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rcv_loss_detect
    import udt_seq_pkg::*;
#(
    parameter logic [31:0] MAX_SEQ_NO = udt_seq_pkg::MAX_SEQ_NO,
    parameter logic [31:0] SEQ_THRESH = udt_seq_pkg::SEQ_THRESH
) (
    input  wire logic        core_clk,
    input  wire logic        core_rst,
    input  wire logic [31:0] init_seq_i,
    input  wire logic        init_valid_i,
    rcv_loss_detect_if.slave bus,
    output logic      [31:0] curr_seq_o,
    output logic      [31:0] loss_cnt_o
);

    rld_state_e  state, state_n;
    logic [30:0] curr, curr_n;
    logic [31:0] loss, loss_n;
    logic [30:0] ins_start, ins_start_n;
    logic [30:0] ins_end, ins_end_n;
    logic [30:0] rem_item, rem_item_n;

    logic [30:0] seq_s;
    logic [30:0] init_s;
    logic [30:0] off;
    logic        off_before;
    logic        off_zero;
    logic [32:0] loss_sum;

    // Bit 31 of the incoming sequence is the control flag and carries no order.
    assign seq_s  = 31'(bus.seq_i & MAX_SEQ_NO);
    assign init_s = 31'(init_seq_i & MAX_SEQ_NO);

    udt_seq_off #(
        .THRESH    (SEQ_THRESH)
    ) u_seq_off (
        .seq       (seq_s),
        .ref_seq   (curr),
        .off       (off),
        .is_before (off_before),
        .is_zero   (off_zero)
    );

    assign loss_sum = {1'b0, loss} + {2'b00, seq_dec(off)};

    always_comb begin
        state_n     = state;
        curr_n      = curr;
        loss_n      = loss;
        ins_start_n = ins_start;
        ins_end_n   = ins_end;
        rem_item_n  = rem_item;

        if (init_valid_i) begin
            curr_n  = seq_dec(init_s);
            state_n = ST_READY;
        end else begin
            case (state)
                ST_READY: begin
                    if (bus.seq_valid_i) begin
                        if (off == 31'd1) begin
                            curr_n = seq_s;
                        end else if (!off_before && !off_zero) begin
                            ins_start_n = seq_inc(curr);
                            ins_end_n   = seq_dec(seq_s);
                            curr_n      = seq_s;
                            loss_n      = loss_sum[32] ? 32'hFFFF_FFFF : loss_sum[31:0];
                            state_n     = ST_INSERT;
                        end else begin
                            rem_item_n = seq_s;
                            state_n    = ST_REMOVE;
                        end
                    end
                end
                ST_INSERT: begin
                    if (bus.insert_ready_i) begin
                        state_n = ST_READY;
                    end
                end
                ST_REMOVE: begin
                    if (bus.remove_ready_i) begin
                        state_n = ST_READY;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state     <= ST_IDLE;
            curr      <= 31'd0;
            loss      <= 32'd0;
            ins_start <= 31'd0;
            ins_end   <= 31'd0;
            rem_item  <= 31'd0;
        end else begin
            state     <= state_n;
            curr      <= curr_n;
            loss      <= loss_n;
            ins_start <= ins_start_n;
            ins_end   <= ins_end_n;
            rem_item  <= rem_item_n;
        end
    end

    assign bus.seq_ready_o    = (state == ST_READY);
    assign bus.insert_valid_o = (state == ST_INSERT);
    assign bus.remove_valid_o = (state == ST_REMOVE);
    assign bus.insertStart_o  = {1'b0, ins_start};
    assign bus.insertEnd_o    = {1'b0, ins_end};
    assign bus.remove_item_o  = {1'b0, rem_item};
    assign curr_seq_o         = {1'b0, curr};
    assign loss_cnt_o         = loss;

endmodule

`default_nettype wire

// File: tb/tb_rcv_loss_detect.sv
// ============================================================================
// Module : tb_rcv_loss_detect
// Brief  : Scoreboard bench for rcv_loss_detect with a sequence-rule model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rcv_loss_detect;

    localparam int unsigned MASK   = 32'h7FFF_FFFF;
    localparam int unsigned THRESH = 32'h3FFF_FFFF;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic [31:0] init_seq_i = '0;
    logic        init_valid_i = 1'b0;
    logic [31:0] curr_seq_o;
    logic [31:0] loss_cnt_o;

    rcv_loss_detect_if bus ();

    rcv_loss_detect dut (
        .core_clk     (core_clk),
        .core_rst     (core_rst),
        .init_seq_i   (init_seq_i),
        .init_valid_i (init_valid_i),
        .bus          (bus),
        .curr_seq_o   (curr_seq_o),
        .loss_cnt_o   (loss_cnt_o)
    );

    always #5 core_clk = ~core_clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned      m_curr = 0;
    longint unsigned  m_loss = 0;
    logic [31:0] ins_start_q[$];
    logic [31:0] ins_end_q[$];
    logic [31:0] rem_q[$];

    int rdy_mode = 1;   // 0 random, 1 low, 2 high

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: classify by modular distance from the largest sequence seen.
    task automatic model_accept(input logic [31:0] v);
        int unsigned s, off;
        s   = v & MASK;
        off = (s - m_curr) & MASK;
        if (off == 1) begin
            m_curr = s;
        end else if (off >= 2 && off <= THRESH) begin
            ins_start_q.push_back((m_curr + 1) & MASK);
            ins_end_q.push_back((s - 1) & MASK);
            m_loss = m_loss + off - 1;
            if (m_loss > 64'hFFFF_FFFF) m_loss = 64'hFFFF_FFFF;
            m_curr = s;
        end else begin
            rem_q.push_back(s);
        end
    endtask

    task automatic clear_expected();
        ins_start_q.delete();
        ins_end_q.delete();
        rem_q.delete();
    endtask

    task automatic send_seq(input logic [31:0] v);
        int budget;
        budget = 0;
        @(posedge core_clk); #1;
        bus.seq_i       = v;
        bus.seq_valid_i = 1'b1;
        @(negedge core_clk);
        while (!bus.seq_ready_o && budget < 200) begin
            @(negedge core_clk);
            budget++;
        end
        if (!bus.seq_ready_o) begin
            chk("seq_ready_timeout", {31'd0, bus.seq_ready_o}, 32'd1);
        end else begin
            @(posedge core_clk);
            model_accept(v);
        end
        #1 bus.seq_valid_i = 1'b0;
    endtask

    task automatic do_init(input logic [31:0] v);
        @(posedge core_clk); #1;
        init_seq_i   = v;
        init_valid_i = 1'b1;
        @(posedge core_clk);
        m_curr = ((v & MASK) - 1) & MASK;
        clear_expected();
        #1 init_valid_i = 1'b0;
    endtask

    task automatic check_status(input string tag);
        @(negedge core_clk);
        chk({tag, "_curr"}, curr_seq_o, m_curr);
        chk({tag, "_loss"}, loss_cnt_o, m_loss[31:0]);
    endtask

    initial begin
        bus.insert_ready_i = 1'b0;
        bus.remove_ready_i = 1'b0;
        forever begin
            @(posedge core_clk); #1;
            case (rdy_mode)
                0: begin
                    bus.insert_ready_i = ($urandom_range(0, 3) != 0);
                    bus.remove_ready_i = ($urandom_range(0, 3) != 0);
                end
                1: begin
                    bus.insert_ready_i = 1'b0;
                    bus.remove_ready_i = 1'b0;
                end
                default: begin
                    bus.insert_ready_i = 1'b1;
                    bus.remove_ready_i = 1'b1;
                end
            endcase
        end
    end

    // Monitor: every presented output is compared against the queue head.
    always @(negedge core_clk) begin
        if (!core_rst) begin
            if (bus.insert_valid_o && bus.remove_valid_o)
                chk("both_valid", 32'd1, 32'd0);
            if (bus.insert_valid_o) begin
                if (ins_start_q.size() == 0) begin
                    chk("insert_unexpected", bus.insertStart_o, 32'hFFFF_FFFF);
                end else begin
                    chk("insert_start", bus.insertStart_o, ins_start_q[0]);
                    chk("insert_end", bus.insertEnd_o, ins_end_q[0]);
                    if (bus.insert_ready_i) begin
                        void'(ins_start_q.pop_front());
                        void'(ins_end_q.pop_front());
                    end
                end
            end
            if (bus.remove_valid_o) begin
                if (rem_q.size() == 0) begin
                    chk("remove_unexpected", bus.remove_item_o, 32'hFFFF_FFFF);
                end else begin
                    chk("remove_item", bus.remove_item_o, rem_q[0]);
                    if (bus.remove_ready_i) void'(rem_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] v;
        int unsigned r, budget;
        bus.seq_i       = '0;
        bus.seq_valid_i = 1'b0;

        #12;
        chk("rst_seq_ready", {31'd0, bus.seq_ready_o}, 32'd0);
        chk("rst_ins_valid", {31'd0, bus.insert_valid_o}, 32'd0);
        chk("rst_rem_valid", {31'd0, bus.remove_valid_o}, 32'd0);
        chk("rst_curr", curr_seq_o, 32'd0);
        chk("rst_loss", loss_cnt_o, 32'd0);
        @(posedge core_clk); #1 core_rst = 1'b0;

        // Back-to-back in-order traffic
        rdy_mode = 2;
        do_init(32'd100);
        @(posedge core_clk); #1;
        bus.seq_valid_i = 1'b1;
        bus.seq_i       = 32'd100;
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            chk("b2b_seq_ready", {31'd0, bus.seq_ready_o}, 32'd1);
            @(posedge core_clk);
            model_accept(32'd100 + i);
            #1 bus.seq_i = 32'd101 + i;
        end
        bus.seq_valid_i = 1'b0;
        check_status("b2b");
        chk("b2b_curr_102", curr_seq_o, 32'd102);

        // Gap with stalled loss list, then a late packet
        rdy_mode = 1;
        do_init(32'd100);
        send_seq(32'd100);
        send_seq(32'd105);
        for (int i = 0; i < 3; i++) begin
            @(negedge core_clk);
            chk("stall_ins_valid", {31'd0, bus.insert_valid_o}, 32'd1);
            chk("stall_seq_ready", {31'd0, bus.seq_ready_o}, 32'd0);
            chk("stall_curr", curr_seq_o, 32'd105);
        end
        rdy_mode = 2;
        send_seq(32'd102);
        check_status("late");

        // Wrap-around gap
        do_init(32'h7FFF_FFFE);
        send_seq(32'h7FFF_FFFE);
        send_seq(32'd2);
        check_status("wrap");

        // Init while an insert is pending
        rdy_mode = 1;
        send_seq(32'd10);
        do_init(32'd500);
        @(negedge core_clk);
        chk("init_drop_ins", {31'd0, bus.insert_valid_o}, 32'd0);
        chk("init_curr", curr_seq_o, 32'd499);
        chk("init_ready", {31'd0, bus.seq_ready_o}, 32'd1);

        // Asynchronous reset mid-insert
        send_seq(32'd600);
        @(posedge core_clk); #3 core_rst = 1'b1;
        #1;
        chk("arst_ins_valid", {31'd0, bus.insert_valid_o}, 32'd0);
        chk("arst_start", bus.insertStart_o, 32'd0);
        chk("arst_curr", curr_seq_o, 32'd0);
        chk("arst_loss", loss_cnt_o, 32'd0);
        chk("arst_seq_ready", {31'd0, bus.seq_ready_o}, 32'd0);
        clear_expected();
        m_curr = 0;
        m_loss = 0;
        @(posedge core_clk); #1 core_rst = 1'b0;
        repeat (2) begin
            @(negedge core_clk);
            chk("idle_seq_ready", {31'd0, bus.seq_ready_o}, 32'd0);
        end

        // Randomised traffic
        rdy_mode = 0;
        do_init($urandom);
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      v = m_curr + 1;
            else if (r < 65) v = m_curr + $urandom_range(2, 12);
            else if (r < 75) v = $urandom;
            else if (r < 88) v = m_curr - $urandom_range(0, 20);
            else             v = m_curr + $urandom_range(32'h3FFF_FFF0, 32'h4000_0010);
            v = (v & MASK) | ({$urandom_range(0, 1), 31'd0});
            if ($urandom_range(0, 99) == 0) do_init($urandom);
            send_seq(v);
            check_status("rand");
        end

        rdy_mode = 2;
        budget = 0;
        while ((bus.insert_valid_o || bus.remove_valid_o) && budget < 50) begin
            @(negedge core_clk);
            budget++;
        end
        @(negedge core_clk);
        chk("drain_ins_q", ins_start_q.size(), 32'd0);
        chk("drain_rem_q", rem_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
